// File: rtl/sequenciador_calc.sv
// Command sequencer for the 4-bit accumulator calculator: owns X, Y, Z and the
// sticky overflow flag, and runs each accepted command through IDLE -> EXEC -> DONE.
module sequenciador_calc #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] disp,
  output logic             disp_stb,
  output logic             overflow,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_CLEAR = OPW'(0);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(1);
  localparam logic [OPW-1:0] OP_HOLD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_DIV2  = OPW'(4);
  localparam logic [OPW-1:0] OP_DISP  = OPW'(5);

  state_t           state, state_nxt;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic             ovf_q;
  logic [WIDTH:0]   sum;

  // Unsigned add keeping the carry in the top bit.
  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] q);
    return {1'b0, p} + {1'b0, q};
  endfunction

  assign sum = add_carry(y_q, x_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && (op_q > OP_DISP);
    disp_stb  = (state == DONE) && (op_q == OP_DISP);
  end

  // Command capture at the accept edge; the cmd inputs are not looked at again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
    end else if (state == IDLE && cmd_valid) begin
      op_q <= cmd_op;
      a_q  <= cmd_a;
    end
  end

  // Results are committed only on the edge that ends EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else if (state == EXEC) begin
      case (op_q)
        OP_CLEAR: begin
          x_q   <= '0;
          y_q   <= '0;
          z_q   <= '0;
          ovf_q <= 1'b0;
        end
        OP_LOAD: x_q <= a_q;
        OP_HOLD: ;
        OP_ADD: begin
          y_q   <= sum[WIDTH-1:0];
          ovf_q <= ovf_q | sum[WIDTH];
        end
        OP_DIV2: y_q <= y_q >> 1;
        OP_DISP: z_q <= y_q;
        default: ;
      endcase
    end
  end

  assign acc      = y_q;
  assign disp     = z_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sequenciador_calc.sv
// Scoreboard bench for sequenciador_calc: a reference model predicts each
// command's results at issue time, and the done monitor pops and compares them.
module tb_sequenciador_calc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] acc, disp;
  logic       disp_stb, overflow, done, err;

  sequenciador_calc #(.WIDTH(4), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .acc(acc), .disp(disp), .disp_stb(disp_stb),
    .overflow(overflow), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] acc;
    logic [3:0] disp;
    logic       ovf;
    logic       err;
    logic       stb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0, last_done = 0, spacing = 0, n_done = 0, run = 0;

  logic [3:0] mx = 4'd0, my = 4'd0, mz = 4'd0;
  logic       mo = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Done monitor: scoreboard pop, ready-low run length and stray pulse checks.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      run = 0;
    end else begin
      if (!cmd_ready) run++;
      else begin
        if (run != 0) check("ready_low_cycles", run, 2);
        run = 0;
      end
      if (done) begin
        n_done++;
        spacing   = cyc - last_done;
        last_done = cyc;
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check("acc", acc, e.acc);
          check("disp", disp, e.disp);
          check("overflow", overflow, e.ovf);
          check("err", err, e.err);
          check("disp_stb", disp_stb, e.stb);
        end
      end
      if ((err || disp_stb) && !done) check("stray_pulse", 1, 0);
    end
  end

  task automatic model_push(input logic [2:0] op, input logic [3:0] a);
    exp_t e;
    logic [4:0] s;
    case (op)
      3'd0: begin mx = 0; my = 0; mz = 0; mo = 0; end
      3'd1: mx = a;
      3'd3: begin s = {1'b0, my} + {1'b0, mx}; my = s[3:0]; mo = mo | s[4]; end
      3'd4: my = my >> 1;
      3'd5: mz = my;
      default: ;
    endcase
    e.acc = my; e.disp = mz; e.ovf = mo; e.err = (op > 3'd5); e.stb = (op == 3'd5);
    q.push_back(e);
  endtask

  // Issue one command and return right after the accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a);
    int n;
    model_push(op, a);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (q.size() != 0) check("done_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    #3;
    check("rst_acc", acc, 0);
    check("rst_disp", disp, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_stb", disp_stb, 0);
    @(negedge clk); rst_n = 1'b1;

    // load / add / overflow / div2 / display / clear
    send(3'd1, 4'd9);
    send(3'd3, 4'd0);
    send(3'd3, 4'd0);
    send(3'd4, 4'd0);
    send(3'd5, 4'd0);
    send(3'd0, 4'd0);
    // illegal opcode with acc=5, then add proves X was untouched
    send(3'd1, 4'd5);
    send(3'd3, 4'd0);
    send(3'd5, 4'd0);
    send(3'd7, 4'hF);
    send(3'd2, 4'd7);
    send(3'd3, 4'd0);
    wait_idle();

    // second command held valid through EXEC/DONE of the first
    send(3'd1, 4'd1);
    send(3'd1, 4'd4);
    wait_idle();
    check("done_spacing", spacing, 3);
    send(3'd3, 4'd0);
    wait_idle();

    // reset during EXEC of add with acc=7, X=3
    send(3'd0, 4'd0);
    send(3'd1, 4'd7);
    send(3'd3, 4'd0);
    send(3'd1, 4'd3);
    wait_idle();
    check("pre_rst_acc", acc, 7);
    nd = n_done;
    send(3'd3, 4'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_acc", acc, 0);
    check("abort_disp", disp, 0);
    check("abort_ovf", overflow, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    void'(q.pop_back());
    mx = 0; my = 0; mz = 0; mo = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", n_done, nd);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_acc", acc, 0);

    send(3'd1, 4'd2);
    send(3'd3, 4'd0);
    wait_idle();
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
